// File: rtl/video_timing_pkg.sv
// Shared constants for the 640x480@60 video timing path and the receiver FSM state type.
package video_timing_pkg;

  localparam int H_ACTIVE = 640;
  localparam int H_TOTAL  = 800;
  localparam int H_SYNC   = 96;
  localparam int V_ACTIVE = 480;
  localparam int V_TOTAL  = 525;
  localparam int V_SYNC   = 2;

  typedef enum logic [1:0] {
    SEARCH,
    MEASURE,
    VERIFY,
    LOCKED
  } rx_state_e;

endpackage

// File: rtl/sync_edge_det.sv
// Registers one sync/DE bit and flags the cycle where the live input enters or leaves level POL.
module sync_edge_det #(
  parameter bit POL = 1'b1
) (
  input  logic clock,
  input  logic reset,
  input  logic d,
  output logic q,
  output logic asserted,
  output logic deasserted
);

  always_ff @(posedge clock) begin
    // NOTE: sequential state uses non-blocking assignment so every flop samples pre-edge values.
    if (reset) q <= 1'b0;
    else       q <= d;
  end

  assign asserted   = (d == POL) && (q != POL);
  assign deasserted = (d != POL) && (q == POL);

endmodule

// File: rtl/video_timing_rx.sv
// Video timing receiver: rebuilds x/y, measures line/frame geometry and declares lock.
// Defining VIDEO_RX_CHECKSUM_EN adds the per-frame rgb sum output frame_sum.
module video_timing_rx
  import video_timing_pkg::*;
#(
  parameter int CW          = 12,
  parameter int XYW         = 10,
  parameter bit SYNC_POL    = 1'b0,
  parameter int LOCK_FRAMES = 2
) (
  input  logic           clock,
  input  logic           reset,
  input  logic           hsync,
  input  logic           vsync,
  input  logic           dataEnable,
  input  logic [23:0]    rgb,
  output logic           pixel_valid,
  output logic [23:0]    rgb_out,
  output logic [XYW-1:0] x,
  output logic [XYW-1:0] y,
  output logic           frame_start,
  output logic           locked,
  output logic [CW-1:0]  h_total,
  output logic [CW-1:0]  h_active,
  output logic [CW-1:0]  v_total,
  output logic [CW-1:0]  v_active,
  output logic [7:0]     err_cnt
`ifdef VIDEO_RX_CHECKSUM_EN
  ,
  output logic [31:0]    frame_sum
`endif
);

  localparam int            MW  = $clog2(LOCK_FRAMES + 1);
  localparam logic [CW-1:0] SAT = '1;

  function automatic logic [CW-1:0] sat_inc(input logic [CW-1:0] v);
    return (v == SAT) ? v : v + 1'b1;
  endfunction

  // A saturated measurement means sync is missing or stuck, so it never counts as a match.
  function automatic logic same(input logic [CW-1:0] a, input logic [CW-1:0] b);
    return (a == b) && (a != SAT);
  endfunction

  logic hs_edge, vs_edge, de_fall;
  logic hs_q, vs_q, hs_rel, vs_rel, de_rise;

  sync_edge_det #(.POL(SYNC_POL)) u_hs (
    .clock(clock), .reset(reset), .d(hsync),
    .q(hs_q), .asserted(hs_edge), .deasserted(hs_rel)
  );
  sync_edge_det #(.POL(SYNC_POL)) u_vs (
    .clock(clock), .reset(reset), .d(vsync),
    .q(vs_q), .asserted(vs_edge), .deasserted(vs_rel)
  );
  sync_edge_det #(.POL(1'b1)) u_de (
    .clock(clock), .reset(reset), .d(dataEnable),
    .q(pixel_valid), .asserted(de_rise), .deasserted(de_fall)
  );

  logic unused_ok;
  assign unused_ok = &{1'b0, hs_q, vs_q, hs_rel, vs_rel, de_rise};

  logic [XYW-1:0] x_cnt;
  logic [CW-1:0]  hcnt, hde, vcnt, vde, h_total_line, h_active_line;
  logic [CW-1:0]  h_total_new, h_total_meas, v_active_new;
  logic           frame_eq;

  assign h_total_new  = sat_inc(hcnt);
  // If no hsync edge arrived for a whole counter range, the stored line total is stale.
  assign h_total_meas = (hcnt == SAT) ? SAT : h_total_line;
  // A DE fall on the vsync edge closes the last line of the ending frame.
  assign v_active_new = de_fall ? sat_inc(vde) : vde;
  assign frame_eq     = same(h_total_meas, h_total) && same(h_active_line, h_active) &&
                        same(vcnt, v_total) && same(v_active_new, v_active);

  rx_state_e      state, state_n;
  logic [MW-1:0]  match_cnt, match_n;
  logic           latch_en, err_hit;

  always_comb begin
    // NOTE: every signal gets a default first so no path leaves one unassigned and infers a latch.
    state_n  = state;
    match_n  = match_cnt;
    latch_en = 1'b0;
    err_hit  = 1'b0;
    case (state)
      SEARCH: if (vs_edge) state_n = MEASURE;
      MEASURE: if (vs_edge) begin
        latch_en = 1'b1;
        match_n  = '0;
        state_n  = VERIFY;
      end
      VERIFY: if (vs_edge) begin
        if (frame_eq) begin
          match_n = match_cnt + 1'b1;
          if (match_n >= MW'(LOCK_FRAMES)) state_n = LOCKED;
        end else begin
          latch_en = 1'b1;
          match_n  = '0;
        end
      end
      LOCKED: if ((hs_edge && !same(h_total_new, h_total)) || (vs_edge && !frame_eq)) begin
        state_n = SEARCH;
        err_hit = 1'b1;
      end
      default: state_n = SEARCH;
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state       <= SEARCH;
      match_cnt   <= '0;
      locked      <= 1'b0;
      frame_start <= 1'b0;
      h_total     <= '0;
      h_active    <= '0;
      v_total     <= '0;
      v_active    <= '0;
      err_cnt     <= '0;
    end else begin
      state       <= state_n;
      match_cnt   <= match_n;
      locked      <= (state_n == LOCKED);
      frame_start <= vs_edge;
      if (latch_en) begin
        h_total  <= h_total_meas;
        h_active <= h_active_line;
        v_total  <= vcnt;
        v_active <= v_active_new;
      end
      if (err_hit && err_cnt != 8'hFF) err_cnt <= err_cnt + 1'b1;
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      rgb_out       <= '0;
      x             <= '0;
      y             <= '0;
      x_cnt         <= '0;
      hcnt          <= '0;
      hde           <= '0;
      vcnt          <= '0;
      vde           <= '0;
      h_total_line  <= '0;
      h_active_line <= '0;
    end else begin
      rgb_out <= rgb;
      x       <= x_cnt;
      if (de_fall)         x_cnt <= '0;
      else if (dataEnable) x_cnt <= x_cnt + 1'b1;
      if (vs_edge)      y <= '0;
      else if (de_fall) y <= y + 1'b1;

      hcnt <= hs_edge ? '0 : sat_inc(hcnt);
      if (hs_edge) h_total_line <= h_total_new;
      if (de_fall) begin
        hde           <= '0;
        h_active_line <= hde;
      end else if (dataEnable) begin
        hde <= sat_inc(hde);
      end

      // An hsync edge coincident with the vsync edge is the first line of the new frame.
      if (vs_edge) begin
        vcnt <= hs_edge ? CW'(1) : '0;
        vde  <= '0;
      end else begin
        if (hs_edge) vcnt <= sat_inc(vcnt);
        if (de_fall) vde  <= sat_inc(vde);
      end
    end
  end

`ifdef VIDEO_RX_CHECKSUM_EN
  logic [31:0] sum_acc;

  always_ff @(posedge clock) begin
    if (reset) begin
      sum_acc   <= '0;
      frame_sum <= '0;
    end else if (vs_edge) begin
      frame_sum <= sum_acc;
      sum_acc   <= dataEnable ? {8'd0, rgb} : '0;
    end else if (dataEnable) begin
      sum_acc <= sum_acc + {8'd0, rgb};
    end
  end
`endif

endmodule

// File: tb/tb_video_timing_rx.sv
// Self-checking bench for video_timing_rx using a scaled-down 40x20 raster with random pixel data.
module tb_video_timing_rx;

  localparam int CW          = 8;
  localparam int XYW         = 10;
  localparam int LOCK_FRAMES = 2;
  localparam bit SP          = 1'b0;
  // Raster: hsync cols [0,HS), DE cols [HB,HB+HA); vsync lines [0,VS), active lines [VB,VB+VA)
  localparam int HT = 40, HA = 32, HS = 4, HB = 6;
  localparam int VT = 20, VA = 16, VS = 2, VB = 3;

  logic           clock = 1'b0;
  logic           reset, hsync, vsync, dataEnable;
  logic [23:0]    rgb;
  logic           pixel_valid, frame_start, locked;
  logic [23:0]    rgb_out;
  logic [XYW-1:0] x, y;
  logic [CW-1:0]  h_total, h_active, v_total, v_active;
  logic [7:0]     err_cnt;
`ifdef VIDEO_RX_CHECKSUM_EN
  logic [31:0]    frame_sum;
`endif

  int          checks   = 0;
  int          failures = 0;
  logic [31:0] sum_acc;

  video_timing_rx #(
    .CW(CW), .XYW(XYW), .SYNC_POL(SP), .LOCK_FRAMES(LOCK_FRAMES)
  ) dut (
    .clock(clock), .reset(reset), .hsync(hsync), .vsync(vsync),
    .dataEnable(dataEnable), .rgb(rgb), .pixel_valid(pixel_valid),
    .rgb_out(rgb_out), .x(x), .y(y), .frame_start(frame_start),
    .locked(locked), .h_total(h_total), .h_active(h_active),
    .v_total(v_total), .v_active(v_active), .err_cnt(err_cnt)
`ifdef VIDEO_RX_CHECKSUM_EN
    , .frame_sum(frame_sum)
`endif
  );

  always #5 clock = ~clock;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d at %0t", tag, got, exp, $time);
    end
  endtask

  // One pixel clock: drive inputs, then sample outputs 1 time unit after the edge.
  task automatic cycle(input bit hs_a, input bit vs_a, input bit de_a,
                       input int col, input int row, input bit vs_start);
    logic [23:0] d;
    logic [31:0] exp_sum;
    d          = 24'($urandom);
    hsync      = hs_a ? SP : ~SP;
    vsync      = vs_a ? SP : ~SP;
    dataEnable = de_a;
    rgb        = d;
    exp_sum    = sum_acc;
    if (vs_start) sum_acc = de_a ? {8'd0, d} : 32'd0;
    else if (de_a) sum_acc = sum_acc + {8'd0, d};
    @(posedge clock);
    #1;
    check("pixel_valid", 64'(pixel_valid), 64'(de_a));
    check("rgb_out", 64'(rgb_out), 64'(d));
    if (de_a) begin
      check("x", 64'(x), 64'(col - HB));
      check("y", 64'(y), 64'(row - VB));
    end
`ifdef VIDEO_RX_CHECKSUM_EN
    if (vs_start) check("frame_sum", 64'(frame_sum), 64'(exp_sum));
`else
    exp_sum = 32'd0;
`endif
  endtask

  task automatic drive_frame(input int short_line, input bit stuck, input bit exp_pre,
                             input bit exp_post, input int stop_at);
    int n;
    int len;
    n = 0;
    check("locked_pre", 64'(locked), 64'(exp_pre));
    for (int l = 0; l < VT; l++) begin
      len = (l == short_line) ? HT - 1 : HT;
      for (int c = 0; c < len; c++) begin
        if (n == stop_at) return;
        cycle(!stuck && (c < HS), l < VS,
              (l >= VB) && (l < VB + VA) && (c >= HB) && (c < HB + HA), c, l, (l == 0) && (c == 0));
        n++;
        if (l == 0 && c == 0) begin
          check("frame_start", 64'(frame_start), 64'd1);
          check("locked_post", 64'(locked), 64'(exp_post));
        end
        if (l == 1 && c == 0) check("frame_start_idle", 64'(frame_start), 64'd0);
        if (short_line >= 0 && l == short_line + 1 && c == 0) begin
          check("short_line_unlock", 64'(locked), 64'd0);
          check("short_line_err", 64'(err_cnt), 64'd1);
        end
      end
    end
  endtask

  task automatic idle_reset();
    reset      = 1'b1;
    hsync      = ~SP;
    vsync      = ~SP;
    dataEnable = 1'b0;
    repeat (2) @(posedge clock);
    #1;
    reset   = 1'b0;
    sum_acc = 32'd0;
    repeat (3) cycle(1'b0, 1'b0, 1'b0, 0, 0, 1'b0);
  endtask

  task automatic check_meas(input string tag);
    check({tag, "_h_total"},  64'(h_total),  64'(HT));
    check({tag, "_h_active"}, 64'(h_active), 64'(HA));
    check({tag, "_v_total"},  64'(v_total),  64'(VT));
    check({tag, "_v_active"}, 64'(v_active), 64'(VA));
  endtask

  initial begin
    int short_line;
    int stop_at;
    reset      = 1'b1;
    hsync      = ~SP;
    vsync      = ~SP;
    dataEnable = 1'b0;
    rgb        = 24'd0;
    sum_acc    = 32'd0;

    idle_reset();
    check("rst_locked", 64'(locked), 64'd0);
    check("rst_err", 64'(err_cnt), 64'd0);
    check("rst_h_total", 64'(h_total), 64'd0);
    check("rst_v_total", 64'(v_total), 64'd0);
    check("rst_frame_start", 64'(frame_start), 64'd0);

    // Lock comes one cycle after the 4th vsync edge from reset.
    for (int f = 1; f <= 4; f++) drive_frame(-1, 1'b0, 1'b0, f == 4, -1);
    check_meas("lock1");
    check("lock1_err", 64'(err_cnt), 64'd0);

    short_line = int'($urandom_range(VT - 3, 1));
    drive_frame(short_line, 1'b0, 1'b1, 1'b1, -1);
    for (int f = 1; f <= 4; f++) drive_frame(-1, 1'b0, 1'b0, f == 4, -1);
    check_meas("relock_short");
    check("relock_short_err", 64'(err_cnt), 64'd1);

    // hsync stuck inactive for a frame: loss is seen on the next vsync edge.
    drive_frame(-1, 1'b1, 1'b1, 1'b1, -1);
    drive_frame(-1, 1'b0, 1'b1, 1'b0, -1);
    check("stuck_err", 64'(err_cnt), 64'd2);
    check("stuck_unlocked", 64'(locked), 64'd0);
    for (int f = 1; f <= 4; f++) drive_frame(-1, 1'b0, 1'b0, f == 4, -1);
    check_meas("relock_stuck");

    stop_at = int'($urandom_range(VB + VA - 2, VB + 1)) * HT + int'($urandom_range(HB + HA - 2, HB + 1));
    drive_frame(-1, 1'b0, 1'b1, 1'b1, stop_at);
    reset      = 1'b1;
    dataEnable = 1'b1;
    rgb        = 24'($urandom) | 24'h1;
    @(posedge clock);
    #1;
    check("mid_rst_pixel_valid", 64'(pixel_valid), 64'd0);
    check("mid_rst_rgb_out", 64'(rgb_out), 64'd0);
    check("mid_rst_x", 64'(x), 64'd0);
    check("mid_rst_y", 64'(y), 64'd0);
    check("mid_rst_locked", 64'(locked), 64'd0);
    check("mid_rst_frame_start", 64'(frame_start), 64'd0);
    check("mid_rst_h_total", 64'(h_total), 64'd0);
    check("mid_rst_h_active", 64'(h_active), 64'd0);
    check("mid_rst_v_total", 64'(v_total), 64'd0);
    check("mid_rst_v_active", 64'(v_active), 64'd0);
    check("mid_rst_err", 64'(err_cnt), 64'd0);
`ifdef VIDEO_RX_CHECKSUM_EN
    check("mid_rst_frame_sum", 64'(frame_sum), 64'd0);
`endif

    // Back in SEARCH: a full four-edge acquisition is needed again.
    idle_reset();
    for (int f = 1; f <= 4; f++) drive_frame(-1, 1'b0, 1'b0, f == 4, -1);
    check_meas("lock_after_rst");
    check("lock_after_rst_err", 64'(err_cnt), 64'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
